mem_copy_dma: RTL

Block-copy initiator for the word-addressed data memory. On a start pulse it copies `length` 32-bit words from `src_addr` to `dst_addr` by driving the memory's address/data/write/read port, then reports completion. It sits between the control path (or a test host) and the memory, and owns the memory port while busy. Memory semantics: a read is requested with `mem_r=1, mem_w=0`; the memory registers the data on the clock edge, so it is valid the following cycle and held until the next read. A write is requested with `mem_w=1, mem_r=0`.

---
 rtl/mem_copy_dma.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: block-copy initiator for the word-addressed data memory.
// Copies `length` words from src_addr to dst_addr, one read and one write
// per word, and pulses done (with error on an out-of-range request).
// Optional build macro: MEM_COPY_OVERLAP_SAFE_EN selects descending copy
// order when dst > src, giving memmove semantics for overlapping ranges.
module mem_copy_dma #(
    parameter int MEM_SIZE = 32,
    parameter int LEN_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_done,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_data,
    output logic             mem_w,
    output logic             mem_r,
    input  logic [31:0]      mem_read_data
);

    typedef enum logic [2:0] {IDLE, CHECK, RD, WR, DONE} state_t;

    state_t           state, state_next;
    logic [31:0]      src_q, dst_q;
    logic [LEN_W-1:0] len_q;
    logic             range_err;

    logic [32:0]      src_end, dst_end;
    logic             range_bad;
    logic             descending;
    logic [LEN_W-1:0] offset;
    logic             last_word;

    // 33-bit end addresses so a huge base plus length cannot wrap past the check
    assign src_end   = {1'b0, src_q} + {{(33-LEN_W){1'b0}}, len_q};
    assign dst_end   = {1'b0, dst_q} + {{(33-LEN_W){1'b0}}, len_q};
    assign range_bad = (src_end > 33'(MEM_SIZE)) || (dst_end > 33'(MEM_SIZE));

`ifdef MEM_COPY_OVERLAP_SAFE_EN
    assign descending = (dst_q > src_q);
`else
    assign descending = 1'b0;
`endif

    // words_done doubles as the progress index; descending order walks it from the top
    assign offset    = descending ? (len_q - words_done - LEN_W'(1)) : words_done;
    assign last_word = ((words_done + LEN_W'(1)) == len_q);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Request latching, range result and progress counting
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            range_err  <= 1'b0;
            words_done <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q      <= src_addr;
                        dst_q      <= dst_addr;
                        len_q      <= length;
                        range_err  <= 1'b0;
                        words_done <= '0;
                    end
                end
                CHECK:   range_err  <= range_bad;
                WR:      words_done <= words_done + LEN_W'(1);
                default: ;
            endcase
        end
    end

    // Next-state decode and memory port / status outputs
    always_comb begin
        state_next  = state;
        busy        = 1'b1;
        done        = 1'b0;
        error       = 1'b0;
        mem_address = '0;
        mem_data    = '0;
        mem_w       = 1'b0;
        mem_r       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = CHECK;
            end
            CHECK: begin
                if (range_bad)          state_next = DONE;
                else if (len_q == '0)   state_next = DONE;
                else                    state_next = RD;
            end
            RD: begin
                mem_r       = 1'b1;
                mem_address = src_q + 32'(offset);
                state_next  = WR;
            end
            WR: begin
                mem_w       = 1'b1;
                mem_address = dst_q + 32'(offset);
                mem_data    = mem_read_data;
                state_next  = last_word ? DONE : RD;
            end
            DONE: begin
                done       = 1'b1;
                error      = range_err;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
